// File: rtl/wave_sequencer.sv
// Program-table scheduler driving the waveform generator select, phase clear and period ticks.
// Optional periods_total status counter is built only when WAVE_SEQ_STATUS_EN is defined.
module wave_sequencer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned AW         = 2,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned SQ_PERIOD  = 20,
  parameter int unsigned SAW_PERIOD = 21,
  parameter int unsigned TRI_PERIOD = 40
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_wr,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [1:0]       cfg_wave,
  input  logic [CNT_W-1:0] cfg_reps,
  input  logic             cfg_last,
  input  logic             start,
  input  logic             stop,
  input  logic             loop_en,
  output logic [1:0]       wave_sel,
  output logic             gen_clr,
  output logic             period_tick,
  output logic [AW-1:0]    seg_idx,
  output logic             busy,
  output logic             done,
  output logic [15:0]      periods_total
);

  localparam int unsigned PMAX = (SQ_PERIOD > SAW_PERIOD) ?
                                 ((SQ_PERIOD > TRI_PERIOD) ? SQ_PERIOD : TRI_PERIOD) :
                                 ((SAW_PERIOD > TRI_PERIOD) ? SAW_PERIOD : TRI_PERIOD);
  localparam int unsigned PW = $clog2(PMAX + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [1:0]       wave_q, wave_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic             last_q, last_d;
  logic [PW-1:0]    phase_q, phase_d;
  logic [CNT_W-1:0] rep_q, rep_d;
  logic             stop_pend_q, stop_pend_d;

  logic [1:0]       tbl_wave [DEPTH];
  logic [CNT_W-1:0] tbl_reps [DEPTH];
  logic             tbl_last [DEPTH];

  logic [PW-1:0]    period_m1;
  logic             tick, stop_now, entry_last, advance, seg_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        tbl_wave[i] <= 2'b11;
        tbl_reps[i] <= '0;
        tbl_last[i] <= 1'b1;
      end
    end else if (cfg_wr && state_q == StIdle) begin
      tbl_wave[cfg_addr] <= cfg_wave;
      tbl_reps[cfg_addr] <= cfg_reps;
      tbl_last[cfg_addr] <= cfg_last;
    end
  end

  // Select 2'b11 is silence: a one-cycle period so reps counts plain cycles.
  always_comb begin
    case (wave_q)
      2'b00:   period_m1 = PW'(SQ_PERIOD - 1);
      2'b01:   period_m1 = PW'(SAW_PERIOD - 1);
      2'b10:   period_m1 = PW'(TRI_PERIOD - 1);
      default: period_m1 = '0;
    endcase
  end

  assign tick       = (state_q == StRun) && (phase_q == period_m1);
  assign stop_now   = stop || stop_pend_q;
  assign entry_last = tbl_last[idx_q] || (idx_q == AW'(DEPTH - 1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wave_d      = wave_q;
    reps_d      = reps_q;
    last_d      = last_q;
    phase_d     = phase_q;
    rep_d       = rep_q;
    stop_pend_d = stop_pend_q || (stop && (state_q == StLoad || state_q == StRun));
    advance     = 1'b0;
    seg_last    = last_q;
    unique case (state_q)
      StIdle: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          state_d = StLoad;
          idx_d   = '0;
        end
      end
      StLoad: begin
        wave_d   = tbl_wave[idx_q];
        reps_d   = tbl_reps[idx_q];
        last_d   = entry_last;
        seg_last = entry_last;
        phase_d  = '0;
        rep_d    = '0;
        if (stop_now)                    state_d = StDone;
        else if (tbl_reps[idx_q] == '0) advance = 1'b1;
        else                             state_d = StRun;
      end
      StRun: begin
        if (tick) begin
          phase_d = '0;
          rep_d   = rep_q + 1'b1;
          if (stop_now)                        state_d = StDone;
          else if (rep_q == reps_q - 1'b1)     advance = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StDone: begin
        state_d     = StIdle;
        stop_pend_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase
    // Stop has already been excluded whenever advance is raised.
    if (advance) begin
      if (!seg_last) begin
        state_d = StLoad;
        idx_d   = idx_q + 1'b1;
      end else if (loop_en) begin
        state_d = StLoad;
        idx_d   = '0;
      end else begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      wave_q      <= 2'b11;
      reps_q      <= '0;
      last_q      <= 1'b1;
      phase_q     <= '0;
      rep_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wave_q      <= wave_d;
      reps_q      <= reps_d;
      last_q      <= last_d;
      phase_q     <= phase_d;
      rep_q       <= rep_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    wave_sel = 2'b11;
    if (state_q == StLoad)     wave_sel = tbl_wave[idx_q];
    else if (state_q == StRun) wave_sel = wave_q;
  end

  assign gen_clr     = (state_q == StLoad);
  assign period_tick = tick;
  assign seg_idx     = idx_q;
  assign busy        = (state_q == StLoad) || (state_q == StRun);
  assign done        = (state_q == StDone);

`ifdef WAVE_SEQ_STATUS_EN
  logic [15:0] ptot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptot_q <= '0;
    end else if (state_q == StIdle && start && !stop) begin
      ptot_q <= '0;
    end else if (tick && ptot_q != 16'hFFFF) begin
      ptot_q <= ptot_q + 16'd1;
    end
  end

  assign periods_total = ptot_q;
`else
  assign periods_total = '0;
`endif

endmodule

// File: tb/tb_wave_sequencer.sv
// Directed self-checking bench for wave_sequencer: timing of ticks, clears, done and lockouts.
module tb_wave_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [1:0]  cfg_wave = '0;
  logic [7:0]  cfg_reps = '0;
  logic        cfg_last = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic [1:0]  wave_sel;
  logic        gen_clr;
  logic        period_tick;
  logic [1:0]  seg_idx;
  logic        busy;
  logic        done;
  logic [15:0] periods_total;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int tick_q[$];
  int clr_q[$];
  int done_q[$];
  logic [3:0] tag_q[$];

  wave_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_wr       (cfg_wr),
    .cfg_addr     (cfg_addr),
    .cfg_wave     (cfg_wave),
    .cfg_reps     (cfg_reps),
    .cfg_last     (cfg_last),
    .start        (start),
    .stop         (stop),
    .loop_en      (loop_en),
    .wave_sel     (wave_sel),
    .gen_clr      (gen_clr),
    .period_tick  (period_tick),
    .seg_idx      (seg_idx),
    .busy         (busy),
    .done         (done),
    .periods_total(periods_total)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle; tag = {seg_idx, wave_sel} at each tick.
  always @(negedge clk) begin
    if (period_tick) begin
      tick_q.push_back(cyc);
      tag_q.push_back({seg_idx, wave_sel});
    end
    if (gen_clr) clr_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_mon();
    tick_q.delete();
    clr_q.delete();
    done_q.delete();
    tag_q.delete();
  endtask

  task automatic wr(input logic [1:0] a, input logic [1:0] w, input logic [7:0] r,
                    input logic l);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wave = w; cfg_reps = r; cfg_last = l;
    step(1);
    cfg_wr = 1'b0;
  endtask

  task automatic start_prog(output int t);
    start = 1'b1;
    t = cyc;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({wave_sel, gen_clr, period_tick, seg_idx, busy, done} !== 8'b11_0_0_00_0_0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want %b",
               {wave_sel, gen_clr, period_tick, seg_idx, busy, done}, 8'b11000000);
    end
    n_cmp++;
    if (periods_total !== 16'd0) begin
      n_err++;
      $display("FAIL reset_periods_total: got %0d want 0", periods_total);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
  endtask

  // Default entry 0 is {11, reps 0, last}: LOAD then DONE.
  task automatic test_reset_table();
    int t;
    clr_mon();
    start_prog(t);
    step(5);
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] != t + 2 || tick_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_table: done %p ticks %p (T=%0d) want done T+2, no ticks",
               done_q, tick_q, t);
    end
  endtask

  task automatic test_single();
    int t;
    wr(2'd0, 2'b00, 8'd2, 1'b1);
    clr_mon();
    start_prog(t);
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_cmp++;
        if (wave_sel !== 2'b00 || gen_clr !== 1'b1) begin
          n_err++;
          $display("FAIL single_load: wave_sel %b gen_clr %b want 00 1", wave_sel, gen_clr);
        end
      end
      if (k == 41) begin
        n_cmp++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL single_busy_T41: got %b want 1", busy);
        end
      end
      if (k == 42) begin
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL single_busy_T42: got %b want 0", busy);
        end
      end
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (tick_q.size() != 2 || tick_q[0] != t + 21 || tick_q[1] != t + 41) begin
      n_err++;
      $display("FAIL single_ticks: got %p (T=%0d) want T+21,T+41", tick_q, t);
    end
    n_cmp++;
    if (clr_q.size() != 1 || clr_q[0] != t + 1) begin
      n_err++;
      $display("FAIL single_clr: got %p (T=%0d) want T+1", clr_q, t);
    end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] != t + 42) begin
      n_err++;
      $display("FAIL single_done: got %p (T=%0d) want T+42", done_q, t);
    end
`ifdef WAVE_SEQ_STATUS_EN
    n_cmp++;
    if (periods_total !== 16'd2) begin
      n_err++;
      $display("FAIL status_total: got %0d want 2", periods_total);
    end
`else
    n_cmp++;
    if (periods_total !== 16'd0) begin
      n_err++;
      $display("FAIL status_total: got %0d want 0", periods_total);
    end
`endif
  endtask

  task automatic test_three();
    int t;
    wr(2'd0, 2'b00, 8'd1, 1'b0);
    wr(2'd1, 2'b01, 8'd1, 1'b0);
    wr(2'd2, 2'b10, 8'd1, 1'b1);
    clr_mon();
    start_prog(t);
    step(90);
    n_cmp++;
    if (tick_q.size() != 3 || tick_q[0] != t + 21 || tick_q[1] != t + 43 ||
        tick_q[2] != t + 84) begin
      n_err++;
      $display("FAIL three_ticks: got %p (T=%0d) want T+21,T+43,T+84", tick_q, t);
    end
    n_cmp++;
    if (tag_q.size() != 3 || tag_q[0] !== 4'b0000 || tag_q[1] !== 4'b0101 ||
        tag_q[2] !== 4'b1010) begin
      n_err++;
      $display("FAIL three_idx_sel: got %p want 0000,0101,1010", tag_q);
    end
    n_cmp++;
    if (clr_q.size() != 3 || clr_q[0] != t + 1 || clr_q[1] != t + 22 || clr_q[2] != t + 44) begin
      n_err++;
      $display("FAIL three_clr: got %p (T=%0d) want T+1,T+22,T+44", clr_q, t);
    end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] != t + 85) begin
      n_err++;
      $display("FAIL three_done: got %p (T=%0d) want T+85", done_q, t);
    end
  endtask

  task automatic test_skip_silence();
    int t;
    wr(2'd0, 2'b11, 8'd0, 1'b0);
    wr(2'd1, 2'b11, 8'd5, 1'b1);
    clr_mon();
    start_prog(t);
    step(12);
    n_cmp++;
    if (clr_q.size() != 2 || clr_q[0] != t + 1 || clr_q[1] != t + 2) begin
      n_err++;
      $display("FAIL skip_clr: got %p (T=%0d) want T+1,T+2", clr_q, t);
    end
    n_cmp++;
    if (tick_q.size() != 5 || tick_q[0] != t + 3 || tick_q[4] != t + 7) begin
      n_err++;
      $display("FAIL silence_ticks: got %p (T=%0d) want T+3..T+7", tick_q, t);
    end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] != t + 8) begin
      n_err++;
      $display("FAIL silence_done: got %p (T=%0d) want T+8", done_q, t);
    end
  endtask

  task automatic test_loop_stop();
    int t;
    wr(2'd0, 2'b01, 8'd3, 1'b1);
    loop_en = 1'b1;
    clr_mon();
    start_prog(t);
    for (int k = 1; k <= 230; k++) begin
      stop = (k == 201);
      @(negedge clk);
      if (k == 200) begin
        n_cmp++;
        if (done_q.size() != 0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL loop_no_done: done %p busy %b want none, 1", done_q, busy);
        end
      end
      if (k == 215) begin
        n_cmp++;
        if (done !== 1'b1 || wave_sel !== 2'b11) begin
          n_err++;
          $display("FAIL stop_done_state: done %b wave_sel %b want 1 11", done, wave_sel);
        end
      end
      @(posedge clk);
      #1;
    end
    stop = 1'b0;
    loop_en = 1'b0;
    n_cmp++;
    if (clr_q.size() != 4 || clr_q[0] != t + 1 || clr_q[1] != t + 65 || clr_q[2] != t + 129 ||
        clr_q[3] != t + 193) begin
      n_err++;
      $display("FAIL loop_clr: got %p (T=%0d) want T+1,65,129,193", clr_q, t);
    end
    n_cmp++;
    if (done_q.size() != 1 || done_q[0] != t + 215 || tick_q.size() == 0 ||
        tick_q[tick_q.size() - 1] != t + 214) begin
      n_err++;
      $display("FAIL stop_timing: done %p ticks %p (T=%0d) want done T+215 last tick T+214",
               done_q, tick_q, t);
    end
  endtask

  task automatic test_lockout();
    int t;
    wr(2'd0, 2'b00, 8'd1, 1'b1);
    clr_mon();
    start_prog(t);
    step(4);
    wr(2'd0, 2'b10, 8'd7, 1'b0);
    step(20);
    clr_mon();
    start_prog(t);
    @(negedge clk);
    n_cmp++;
    if (wave_sel !== 2'b00) begin
      n_err++;
      $display("FAIL lockout_table: wave_sel got %b want 00", wave_sel);
    end
    step(25);
    n_cmp++;
    if (tick_q.size() != 1 || tick_q[0] != t + 21 || done_q.size() != 1 ||
        done_q[0] != t + 22) begin
      n_err++;
      $display("FAIL lockout_run: ticks %p done %p (T=%0d) want T+21, T+22", tick_q, done_q, t);
    end
    // start and stop together must be refused
    clr_mon();
    start = 1'b1;
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || gen_clr !== 1'b0) begin
      n_err++;
      $display("FAIL start_stop_prio: busy %b gen_clr %b want 0 0", busy, gen_clr);
    end
    step(3);
    n_cmp++;
    if (clr_q.size() != 0 || done_q.size() != 0) begin
      n_err++;
      $display("FAIL start_stop_idle: clr %p done %p want none", clr_q, done_q);
    end
    // asynchronous reset in the middle of a period
    start_prog(t);
    step(10);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || wave_sel !== 2'b11 || periods_total !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset: busy %b wave_sel %b total %0d want 0 11 0",
               busy, wave_sel, periods_total);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    test_reset();
    test_reset_table();
    test_single();
    test_three();
    test_skip_silence();
    test_loop_stop();
    test_lockout();
    test_reset_table();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
